// File: rtl/lsu_pkg.sv
// Shared size encodings and byte-lane helpers for the LSU store path.
// Helpers operate on a 32-bit word with four byte lanes.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [3:0] size_to_strb(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 4'b0001 << addr_lo;
      SZ_H:    return 4'b0011 << addr_lo;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [31:0] data, input logic [1:0] size);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // size 3 is handled as a word access
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Combinational byte merge of buffered stores over the SRAM word for a load.
// Entries are walked oldest to youngest so the youngest matching byte wins.
module sb_fwd_merge #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0]                 head_idx,
  input  logic [IDX_W:0]                   count,
  input  logic [DEPTH-1:0][ADDR_W-3:0]     ent_addr,
  input  logic [DEPTH-1:0][STRB_W-1:0]     ent_strb,
  input  logic [DEPTH-1:0][DATA_W-1:0]     ent_data,
  input  logic [ADDR_W-3:0]                ld_word,
  input  logic [DATA_W-1:0]                sram_rdata,
  output logic [DATA_W-1:0]                merged
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    merged = sram_rdata;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + IDX_W'(k);
      if (((IDX_W+1)'(k) < count) && (ent_addr[idx] == ld_word)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (ent_strb[idx][b]) merged[8*b +: 8] = ent_data[idx][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// Store buffer between EXE and data SRAM: speculative entries, WB commit,
// oldest-first drain over req/ack, and byte-granular load forwarding.
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_wdata,
  input  logic [1:0]                 st_size,
  output logic                       st_ale,
  input  logic                       commit,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [1:0]                 ld_size,
  input  logic                       ld_unsigned,
  input  logic [DATA_W-1:0]          ld_sram_rdata,
  output logic [DATA_W-1:0]          ld_result,
  output logic                       ld_ale,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int WA_W   = ADDR_W - 2;

  logic [PTR_W-1:0] head, cmt, tail;
  logic [PTR_W-1:0] count, cmt_next;
  logic [DEPTH-1:0][WA_W-1:0]   ent_addr;
  logic [DEPTH-1:0][STRB_W-1:0] ent_strb;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  logic full, enq, commit_fire, ack_fire;
  logic [DATA_W-1:0] merged, shifted;

  assign count       = tail - head;
  assign full        = count == PTR_W'(DEPTH);
  assign sb_count    = count;
  assign sb_empty    = count == '0;

  assign st_ale      = is_misaligned(st_addr[1:0], st_size);
  assign ld_ale      = is_misaligned(ld_addr[1:0], ld_size);
  // a drain retiring this cycle does not open a slot until the next one
  assign st_ready    = !full && !flush;
  assign enq         = st_valid && st_ready && !st_ale;
  assign commit_fire = commit && (cmt != tail);
  assign ack_fire    = mem_ack && mem_req;
  assign cmt_next    = cmt + {{IDX_W{1'b0}}, commit_fire};

  assign mem_req   = head != cmt;
  assign mem_addr  = {ent_addr[head[IDX_W-1:0]], 2'b00};
  assign mem_wstrb = ent_strb[head[IDX_W-1:0]];
  assign mem_wdata = ent_data[head[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + {{IDX_W{1'b0}}, ack_fire};
      cmt  <= cmt_next;
      // flush drops everything younger than the (post-commit) commit point
      tail <= flush ? cmt_next : tail + {{IDX_W{1'b0}}, enq};
      if (enq) begin
        ent_addr[tail[IDX_W-1:0]] <= st_addr[ADDR_W-1:2];
        ent_strb[tail[IDX_W-1:0]] <= size_to_strb(st_size, st_addr[1:0]);
        ent_data[tail[IDX_W-1:0]] <= lane_replicate(st_wdata, st_size);
      end
    end
  end

  sb_fwd_merge #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .STRB_W (STRB_W),
    .IDX_W  (IDX_W)
  ) u_fwd (
    .head_idx   (head[IDX_W-1:0]),
    .count      (count),
    .ent_addr   (ent_addr),
    .ent_strb   (ent_strb),
    .ent_data   (ent_data),
    .ld_word    (ld_addr[ADDR_W-1:2]),
    .sram_rdata (ld_sram_rdata),
    .merged     (merged)
  );

  assign shifted = merged >> {ld_addr[1:0], 3'b000};

  always_comb begin
    case (ld_size)
      SZ_B: ld_result = ld_unsigned ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                    : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      SZ_H: ld_result = ld_unsigned ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                    : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      default: ld_result = merged;
    endcase
  end

endmodule

// File: doc/lsu_store_buffer.md
Name: lsu_store_buffer

Overview:
Parametrised store buffer and load-merge unit between the EXE stage and data SRAM.
- Accepts sized stores from EXE, holds them speculatively until WB commits them, and drains committed entries to SRAM oldest-first over a req/ack handshake.
- Forwards buffered bytes to loads in EXE, then sign- or zero-extends the merged word.
- Replaces single-entry MEM/WB store forwarding with a DEPTH-entry, byte-granular, flush-aware structure.

Parameters:
DEPTH, 4, number of entries; power of two, ≥2.
ADDR_W, 32, byte address width.
DATA_W, 32, data width; STRB_W = DATA_W/8.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  pipeline flush (exception/ertn); kills uncommitted entries
st_valid  in  1  EXE store request
st_ready  out  1  entry available
st_addr  in  ADDR_W  store byte address
st_wdata  in  DATA_W  store data, low-aligned
st_size  in  2  0=byte, 1=half, 2=word
st_ale  out  1  combinational misalignment flag for the current st_addr/st_size
commit  in  1  WB retires oldest uncommitted store
ld_addr  in  ADDR_W  EXE load byte address
ld_size  in  2  as st_size
ld_unsigned  in  1  zero-extend (ld.bu/ld.hu)
ld_sram_rdata  in  DATA_W  raw SRAM word for ld_addr
ld_result  out  DATA_W  merged, extended load data
ld_ale  out  1  load misalignment flag
mem_req  out  1  drain request
mem_addr  out  ADDR_W  word-aligned drain address
mem_wstrb  out  STRB_W  byte strobes
mem_wdata  out  DATA_W  lane-shifted drain data
mem_ack  in  1  SRAM accepted drain
sb_empty  out  1  no valid entries
sb_count  out  clog2(DEPTH)+1  valid entry count

Behaviour:
Reset values:
- All pointers = 0; all entry valid bits clear.
- Outputs: st_ready=1, mem_req=0, sb_empty=1, sb_count=0.
- Reset mid-drain abandons the entry without completing it.

Pointers:
- head (drain), cmt (next to commit) and tail (enqueue), each clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Invariant: head ≤ cmt ≤ tail (modular).
- full when tail−head == DEPTH.

Alignment check:
- ale = (size==1 && addr[0]) || (size==2 && addr[1:0]!=0).
- size 3 is treated as word.

Enqueue:
- Fires when st_valid && st_ready && !st_ale.
- Stores {word_addr, strb, lane-shifted data} at tail, then tail+1.
- strb: byte = 1<<addr[1:0], half = 3<<addr[1:0], word = 4'hF.
- Data is replicated across lanes: byte → {4{b}}, half → {2{h}}.
- A misaligned store is not enqueued.
- st_ready = !full && !flush.
- No same-cycle full bypass: a drain in the same cycle does not free space for an enqueue.

Commit:
- cmt+1 if cmt != tail; otherwise ignored.

Flush:
- Processed after any same-cycle commit: tail <= (commit ? cmt+1 : cmt).
- An enqueue in the same cycle is dropped.
- Committed entries and an in-flight drain are unaffected.

Drain:
- mem_req = (head != cmt); mem_addr/wstrb/wdata come from entry[head].
- All drain outputs stay stable until mem_ack.
- mem_ack && mem_req → head+1.
- mem_ack without mem_req is ignored.

Forwarding (combinational, all entries head..tail−1):
- For each byte lane, take the youngest entry with matching word address and that strobe bit set.
- Otherwise take ld_sram_rdata's byte.
- Then select lanes by ld_addr[1:0] and ld_size, and extend.
- ld_result must not depend on mem_ack in the same cycle.

Simultaneous events:
- Enqueue, commit, ack and flush may all occur in one cycle.
- Each pointer updates independently per the rules above; sb_count is recomputed from the new pointers.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2;
  - functions size_to_strb(size, addr_lo), lane_replicate(data, size), is_misaligned(addr_lo, size).
- One sub-module, sb_fwd_merge: purely combinational youngest-match byte merge over the entry array, parametrised by DEPTH.

Test Plan:
1. Reset, then st.w 0x1000=0xDEADBEEF, no commit → mem_req stays 0, sb_count=1; ld.w 0x1000 with sram=0 → ld_result=0xDEADBEEF.
2. st.b 0x2001=0xAB, then st.b 0x2001=0xCD; ld.bu 0x2001, sram=0x11223344 → ld_result=0x000000CD (youngest wins). ld.w 0x2000 → 0x1122CD44. ld.b 0x2001 after st.b 0x80 → 0xFFFFFF80.
3. Fill DEPTH=4 stores → st_ready=0. Commit 2 → mem_req=1, addr from entry0. Hold mem_ack=0 for 3 cycles → outputs stable. Ack → head advances, st_ready=1.
4. 3 stores, commit 1, then flush with commit in the same cycle → tail=cmt=2, sb_count=2, both drain in order, and the third store's data is never seen on mem_wdata.
5. st.h at 0x3001 → st_ale=1, not enqueued, sb_count unchanged. ld.w at 0x3002 → ld_ale=1.
6. Full buffer with enqueue and mem_ack in the same cycle → enqueue refused, head+1, sb_count=3. Next cycle the enqueue is accepted.
